// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for mem_port_arbiter: channel-index width,
// flattened-bus slice offsets and the data returned for write acknowledges.
package mem_port_arbiter_pkg;

  localparam int RESP_WR_DATA = 32'sd0;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < n) r = i + 32'sd1;
    end
    return r;
  endfunction

  // Width of r_ch / h_ch / rr_ptr; never zero so a 1-channel build still elaborates.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 32'sd1) ? clog2(num_ch) : 32'sd1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Grant selector: first requesting channel scanning upward from ptr with wrap.
// With MEMARB_FIXED_PRIO_EN defined the scan always starts at channel 0.
module rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] w_start;
  int              w_scan_idx;
  logic            w_found;

`ifdef MEMARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;
  assign w_start      = '0;
`else
  assign w_start = ptr;
`endif

  // Wrapping priority scan; the first hit wins and later hits are ignored.
  always_comb begin
    gnt        = '0;
    gnt_idx    = '0;
    w_found    = 1'b0;
    w_scan_idx = 32'sd0;
    for (int i = 32'sd0; i < NUM_CH; i++) begin
      w_scan_idx = (int'(w_start) + i) % NUM_CH;
      if (!w_found && req[w_scan_idx]) begin
        w_found         = 1'b1;
        gnt[w_scan_idx] = 1'b1;
        gnt_idx         = CH_W'(w_scan_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency SRAM among NUM_CH requesters with a one-entry
// response hold buffer. Define MEMARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W = DATA_W / 8,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*BE_W-1:0]   req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        resp_valid,
  input  logic [NUM_CH-1:0]        resp_ready,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     sram_en,
  output logic [BE_W-1:0]          sram_we,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [DATA_W-1:0]        sram_rdata
);

  logic              r_valid;
  logic [CH_W-1:0]   r_ch;
  logic              r_wr;
  logic              r_h_valid;
  logic [CH_W-1:0]   r_h_ch;
  logic [DATA_W-1:0] r_h_data;
  logic [CH_W-1:0]   r_rr_ptr;

  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_next_ptr;
  logic [BE_W-1:0]   w_g_we;
  logic              w_r_stall;
  logic              w_issue_ok;
  logic              w_fire;
  logic [DATA_W-1:0] w_resp_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // A stalled response in r or anything in h blocks new issue, capping outstanding at two.
  assign w_r_stall  = r_valid & ~resp_ready[r_ch];
  assign w_issue_ok = ~r_h_valid & ~w_r_stall;
  assign w_fire     = w_issue_ok & (|req_valid) & ~rst;
  assign w_g_we     = req_we[slice_lo(int'(w_gnt_idx), BE_W) +: BE_W];
  assign w_next_ptr = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : (w_gnt_idx + CH_W'(1));

  // Request side: grant handshake and SRAM command, idle during reset.
  always_comb begin
    req_ready  = '0;
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = req_addr[slice_lo(int'(w_gnt_idx), ADDR_W) +: ADDR_W];
    sram_wdata = req_wdata[slice_lo(int'(w_gnt_idx), DATA_W) +: DATA_W];
    if (w_fire) begin
      req_ready = w_gnt;
      sram_en   = 1'b1;
      sram_we   = w_g_we;
    end else begin
      req_ready = '0;
    end
  end

  // Response side: the hold buffer takes precedence over the live SRAM stage.
  always_comb begin
    resp_valid  = '0;
    w_resp_data = r_wr ? DATA_W'(RESP_WR_DATA) : sram_rdata;
    if (r_h_valid) begin
      w_resp_data = r_h_data;
    end else begin
      w_resp_data = w_resp_data;
    end
    if (rst) begin
      resp_valid = '0;
    end else if (r_h_valid) begin
      resp_valid[r_h_ch] = 1'b1;
    end else if (r_valid) begin
      resp_valid[r_ch] = 1'b1;
    end else begin
      resp_valid = '0;
    end
  end

  assign resp_rdata = w_resp_data;

  // Response stage, hold buffer and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ch      <= '0;
      r_wr      <= 1'b0;
      r_h_valid <= 1'b0;
      r_h_ch    <= '0;
      r_h_data  <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_valid <= w_fire;
      if (w_fire) begin
        r_ch     <= w_gnt_idx;
        r_wr     <= |w_g_we;
        r_rr_ptr <= w_next_ptr;
      end
      // SRAM data is only valid for one cycle, so a refused response must be captured now.
      if (r_valid && !r_h_valid && !resp_ready[r_ch]) begin
        r_h_valid <= 1'b1;
        r_h_ch    <= r_ch;
        r_h_data  <= w_resp_data;
      end else if (r_h_valid && resp_ready[r_h_ch]) begin
        r_h_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors push expected SRAM
// commands and responses; negedge monitors pop and compare.
module tb_mem_port_arbiter;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*BE_W-1:0]   req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        resp_valid;
  logic [NUM_CH-1:0]        resp_ready;
  logic [DATA_W-1:0]        resp_rdata;
  logic                     sram_en;
  logic [BE_W-1:0]          sram_we;
  logic [ADDR_W-1:0]        sram_addr;
  logic [DATA_W-1:0]        sram_wdata;
  logic [DATA_W-1:0]        sram_rdata;

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  typedef struct {
    logic [1:0]  ch_oh;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    logic [1:0]  ch_oh;
    logic [31:0] data;
  } resp_t;

  issue_t exp_issue[$];
  resp_t  exp_resp[$];
  int     n_checks = 0;
  int     n_errors = 0;

  // SRAM model: fixed base contents, byte-merged writes, registered read data.
  bit          mem_wr [0:255];
  logic [31:0] mem    [0:255];

  function automatic logic [31:0] base_word(input logic [7:0] idx);
    case (idx)
      8'h40:   return 32'hDEADBEEF;
      8'h41:   return 32'hCAFEF00D;
      8'h42:   return 32'hAAAAAAAA;
      8'h80:   return 32'h000055AA;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] idx);
    return mem_wr[idx] ? mem[idx] : base_word(idx);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      if (|sram_we) begin
        mem[sram_addr[9:2]]    <= merge(mem_word(sram_addr[9:2]), sram_we, sram_wdata);
        mem_wr[sram_addr[9:2]] <= 1'b1;
      end
      sram_rdata <= mem_word(sram_addr[9:2]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  // Issue monitor: every SRAM command must match the next expected grant.
  always @(negedge clk) begin
    if (sram_en) begin
      if (exp_issue.size() == 0) begin
        unexpected("issue_unexpected");
      end else begin
        chk("issue_grant", 64'(req_ready), 64'(exp_issue[0].ch_oh));
        chk("issue_addr",  64'(sram_addr), 64'(exp_issue[0].addr));
        chk("issue_we",    64'(sram_we),   64'(exp_issue[0].we));
        chk("issue_wdata", 64'(sram_wdata), 64'(exp_issue[0].wdata));
        void'(exp_issue.pop_front());
      end
    end
  end

  // Response monitor: every consumed response must match the next expected one.
  always @(negedge clk) begin
    if (|(resp_valid & resp_ready)) begin
      if (exp_resp.size() == 0) begin
        unexpected("resp_unexpected");
      end else begin
        chk("resp_channel", 64'(resp_valid), 64'(exp_resp[0].ch_oh));
        chk("resp_data",    64'(resp_rdata), 64'(exp_resp[0].data));
        void'(exp_resp.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] rready,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] we1, input logic [31:0] wd1);
    req_valid  = valid;
    resp_ready = rready;
    req_addr   = {a1, a0};
    req_we     = {we1, 4'h0};
    req_wdata  = {wd1, 32'h0};
  endtask

  task automatic push_rd(input logic [1:0] oh, input logic [31:0] addr, input logic [31:0] data);
    exp_issue.push_back('{oh, addr, 4'h0, 32'h0});
    exp_resp.push_back('{oh, data});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(2'b11, 2'b11, 32'h100, 32'h104, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready",  64'(req_ready),  64'd0);
    chk("reset_sram_en",    64'(sram_en),    64'd0);
    chk("reset_sram_we",    64'(sram_we),    64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);

    // Contention: both channels request for four cycles.
`ifdef MEMARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_rd(2'b01, 32'h100, 32'hDEADBEEF);
`else
    for (int i = 0; i < 2; i++) begin
      push_rd(2'b01, 32'h100, 32'hDEADBEEF);
      push_rd(2'b10, 32'h104, 32'hCAFEF00D);
    end
`endif
    step(); rst = 1'b0;
    repeat (3) step();
    step(); drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0);
    step();

    // Single read with one-cycle latency.
    push_rd(2'b01, 32'h100, 32'hDEADBEEF);
    step(); drive(2'b01, 2'b11, 32'h100, 32'h0, 4'h0, 32'h0);
    step(); drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("single_read_valid", 64'(resp_valid), 64'd1);
    chk("single_read_data",  64'(resp_rdata), 64'hDEADBEEF);

    // Partial write acknowledge, then read back the merged word.
    exp_issue.push_back('{2'b10, 32'h108, 4'b0011, 32'h12345678});
    exp_resp.push_back('{2'b10, 32'h0});
    step(); drive(2'b10, 2'b11, 32'h0, 32'h108, 4'b0011, 32'h12345678);
    step(); drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("write_ack_valid", 64'(resp_valid), 64'd2);
    chk("write_ack_data",  64'(resp_rdata), 64'd0);
    push_rd(2'b01, 32'h108, 32'hAAAA5678);
    step(); drive(2'b01, 2'b11, 32'h108, 32'h0, 4'h0, 32'h0);
    step(); drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0);

    // Backpressure on ch1 for three cycles while ch0 waits.
    push_rd(2'b10, 32'h200, 32'h000055AA);
    push_rd(2'b01, 32'h100, 32'hDEADBEEF);
    step(); drive(2'b10, 2'b01, 32'h100, 32'h200, 4'h0, 32'h0);
    step(); drive(2'b01, 2'b01, 32'h100, 32'h200, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("bp_stall_req_ready", 64'(req_ready), 64'd0);
      chk("bp_stall_resp_valid", 64'(resp_valid), 64'd2);
    end
    step(); resp_ready = 2'b11;
    @(negedge clk);
    chk("bp_drain_req_ready", 64'(req_ready), 64'd0);
    chk("bp_drain_data",      64'(resp_rdata), 64'h000055AA);
    step();
    @(negedge clk);
    chk("bp_resume_req_ready", 64'(req_ready), 64'd1);
    step(); drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0);
    step();

    // Reset while a response sits in the hold buffer.
    exp_issue.push_back('{2'b01, 32'h100, 4'h0, 32'h0});
    step(); drive(2'b01, 2'b00, 32'h100, 32'h104, 4'h0, 32'h0);
    step(); drive(2'b00, 2'b00, 32'h100, 32'h104, 4'h0, 32'h0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready",  64'(req_ready),  64'd0);
    push_rd(2'b01, 32'h100, 32'hDEADBEEF);
    step(); rst = 1'b0; drive(2'b11, 2'b11, 32'h100, 32'h104, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_rst_grant",      64'(req_ready),  64'd1);
    step(); drive(2'b00, 2'b11, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (3) step();
    @(negedge clk);
    chk("issue_queue_empty", 64'(exp_issue.size()), 64'd0);
    chk("resp_queue_empty",  64'(exp_resp.size()),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
